// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP issue/retire sequencer.
//   - 3-bit opcode encodings OP_ADD .. OP_NEG
//   - sequencer state encoding (IDLE / EXEC / DONE)
//   - helpers to size the latency counter and classify opcodes
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;
    localparam logic [2:0] OP_ABS  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_NEG  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int max_lat(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Bits needed to hold 0..max; never narrower than one bit so that an
    // all-zero-latency configuration still has a legal counter.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Opcodes served by an external arithmetic unit (the rest are internal).
    function automatic logic is_unit_op(input logic [2:0] op);
        return (op <= OP_SQRT);
    endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// fpu_seq_if: bundle of the sequencer's issue, unit and result signals.
//   Issue : in_valid, in_ready, in_op, in_a, in_b
//   Units : unit_a, unit_b (to units), add/sub/mul/div/sqrt_res (from units)
//   Result: out_valid, out_ready, out_data
// Handshake rule for both issue and result channels: a transfer happens on a
// rising clock edge where valid and ready are both high. Once the producer
// raises valid it holds valid and its payload unchanged until that transfer;
// ready may be asserted or withdrawn freely and never depends on a future edge.
// slave = sequencer side, master = core/units side.
interface fpu_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] unit_a;
    logic [W-1:0] unit_b;
    logic [W-1:0] add_res;
    logic [W-1:0] sub_res;
    logic [W-1:0] mul_res;
    logic [W-1:0] div_res;
    logic [W-1:0] sqrt_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  add_res, sub_res, mul_res, div_res, sqrt_res,
        input  out_ready,
        output in_ready, unit_a, unit_b, out_valid, out_data
    );

    modport master (
        output in_valid, in_op, in_a, in_b,
        output add_res, sub_res, mul_res, div_res, sqrt_res,
        output out_ready,
        input  in_ready, unit_a, unit_b, out_valid, out_data
    );
endinterface

// File: rtl/fpu_lat_mux.sv
// fpu_lat_mux: combinational opcode decode for the sequencer datapath.
//   op_i        : opcode being selected
//   b_i         : sole operand for abs/mov/neg
//   *_res_i     : external unit results
//   res_o       : unit result or internally computed abs/mov/neg value
//   lat_o       : pipeline depth of the unit serving op_i (0 for internal ops)
module fpu_lat_mux
    import fpu_pkg::*;
#(
    parameter int W        = 32,
    parameter int CW       = 2,
    parameter int LAT_ADD  = 1,
    parameter int LAT_SUB  = 1,
    parameter int LAT_MUL  = 0,
    parameter int LAT_DIV  = 3,
    parameter int LAT_SQRT = 2
) (
    input  logic [2:0]    op_i,
    input  logic [W-1:0]  b_i,
    input  logic [W-1:0]  add_res_i,
    input  logic [W-1:0]  sub_res_i,
    input  logic [W-1:0]  mul_res_i,
    input  logic [W-1:0]  div_res_i,
    input  logic [W-1:0]  sqrt_res_i,
    output logic [W-1:0]  res_o,
    output logic [CW-1:0] lat_o
);

    always_comb begin
        res_o = '0;
        lat_o = '0;
        case (op_i)
            OP_ADD:  begin res_o = add_res_i;  lat_o = CW'(LAT_ADD);  end
            OP_SUB:  begin res_o = sub_res_i;  lat_o = CW'(LAT_SUB);  end
            OP_MUL:  begin res_o = mul_res_i;  lat_o = CW'(LAT_MUL);  end
            OP_DIV:  begin res_o = div_res_i;  lat_o = CW'(LAT_DIV);  end
            OP_SQRT: begin res_o = sqrt_res_i; lat_o = CW'(LAT_SQRT); end
            // Sign-bit manipulation only: clear, keep or flip bit W-1.
            OP_ABS:  res_o = {1'b0, b_i[W-2:0]};
            OP_MOV:  res_o = b_i;
            OP_NEG:  res_o = {~b_i[W-1], b_i[W-2:0]};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: FP issue/retire sequencer. Accepts one op per issue handshake,
// latches opcode and operands, drives the operands to the free-running
// arithmetic units, waits the per-opcode latency, then presents the selected
// result on the result handshake, holding it under backpressure.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous abort of the in-flight op
//   bus         : issue / unit / result signals (slave side)
//   busy        : high whenever the sequencer is not IDLE
//   dbg_state_o : current FSM state
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int W        = 32,
    parameter int LAT_ADD  = 1,
    parameter int LAT_SUB  = 1,
    parameter int LAT_MUL  = 0,
    parameter int LAT_DIV  = 3,
    parameter int LAT_SQRT = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    fpu_seq_if.slave bus,
    output logic     busy,
    output state_e   dbg_state_o
);

    localparam int CW = cnt_width(max_lat(LAT_ADD, LAT_SUB, LAT_MUL, LAT_DIV, LAT_SQRT));

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q, b_q, data_q;

    logic          in_ready;
    logic          out_valid;
    logic          accept;
    logic          cnt_zero;
    state_e        accept_state;
    logic [2:0]    sel_op;
    logic [W-1:0]  sel_b;
    logic [W-1:0]  sel_res;
    logic [CW-1:0] sel_lat;

    assign accept       = bus.in_valid & in_ready;
    assign cnt_zero     = (cnt_q == '0);
    assign accept_state = is_unit_op(bus.in_op) ? ST_EXEC : ST_DONE;

    // On the accept edge the decode must see the incoming op (its latency and,
    // for abs/mov/neg, its result); afterwards it serves the latched op.
    assign sel_op = accept ? bus.in_op : op_q;
    assign sel_b  = accept ? bus.in_b  : b_q;

    fpu_lat_mux #(
        .W        (W),
        .CW       (CW),
        .LAT_ADD  (LAT_ADD),
        .LAT_SUB  (LAT_SUB),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT)
    ) u_lat_mux (
        .op_i       (sel_op),
        .b_i        (sel_b),
        .add_res_i  (bus.add_res),
        .sub_res_i  (bus.sub_res),
        .mul_res_i  (bus.mul_res),
        .div_res_i  (bus.div_res),
        .sqrt_res_i (bus.sqrt_res),
        .res_o      (sel_res),
        .lat_o      (sel_lat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = accept_state;
            end
            ST_EXEC: begin
                if (cnt_zero) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Retiring and issuing on the same edge chains ops with no bubble.
                if (bus.out_ready) state_d = accept ? accept_state : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Output logic
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        dbg_state_o = state_q;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: busy     = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: ;
        endcase
        // A flush cycle never accepts a new op.
        if (flush) in_ready = 1'b0;
    end

    // Datapath: operand latches, latency counter, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= bus.in_op;
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            cnt_q <= sel_lat;
            if (!is_unit_op(bus.in_op)) data_q <= sel_res;
        end else if (state_q == ST_EXEC) begin
            if (cnt_zero) data_q <= sel_res;
            else          cnt_q  <= cnt_q - 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.unit_a    = a_q;
    assign bus.unit_b    = b_q;

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: bench for fpu_seq. Arithmetic units are delay-line models of
// binary32 add/sub/mul/div/sqrt built on the simulator's real arithmetic.
module tb_fpu_seq;
  import fpu_pkg::*;

  localparam int W        = 32;
  localparam int LAT_ADD  = 1;
  localparam int LAT_SUB  = 1;
  localparam int LAT_MUL  = 0;
  localparam int LAT_DIV  = 3;
  localparam int LAT_SQRT = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  logic   flush;
  logic   busy;
  state_e dbg_state;
  int     n_tests = 0;
  int     n_fail  = 0;

  always #5 clk = ~clk;

  fpu_seq_if #(.W(W)) bus ();

  fpu_seq #(
    .W(W), .LAT_ADD(LAT_ADD), .LAT_SUB(LAT_SUB), .LAT_MUL(LAT_MUL),
    .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- binary32 helpers (normal numbers only) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(100, 150));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  // ---------------- unit models ----------------
  logic [31:0] add_q, sub_q;
  logic [31:0] div_q [3];
  logic [31:0] sqrt_q[2];

  always @(posedge clk) begin
    add_q     <= r2f(f2r(bus.unit_a) + f2r(bus.unit_b));
    sub_q     <= r2f(f2r(bus.unit_a) - f2r(bus.unit_b));
    div_q[0]  <= r2f(f2r(bus.unit_a) / f2r(bus.unit_b));
    div_q[1]  <= div_q[0];
    div_q[2]  <= div_q[1];
    sqrt_q[0] <= r2f($sqrt(f2r(bus.unit_b & 32'h7fffffff)));
    sqrt_q[1] <= sqrt_q[0];
  end

  assign bus.add_res  = add_q;
  assign bus.sub_res  = sub_q;
  assign bus.mul_res  = r2f(f2r(bus.unit_a) * f2r(bus.unit_b));
  assign bus.div_res  = div_q[2];
  assign bus.sqrt_res = sqrt_q[1];

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return r2f(f2r(a) + f2r(b));
      OP_SUB:  return r2f(f2r(a) - f2r(b));
      OP_MUL:  return r2f(f2r(a) * f2r(b));
      OP_DIV:  return r2f(f2r(a) / f2r(b));
      OP_SQRT: return r2f($sqrt(f2r(b & 32'h7fffffff)));
      OP_ABS:  return b & 32'h7fffffff;
      OP_MOV:  return b;
      default: return b ^ 32'h80000000;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen high.
  function automatic int exp_lat(input logic [2:0] op);
    case (op)
      OP_ADD:  return 1 + LAT_ADD;
      OP_SUB:  return 1 + LAT_SUB;
      OP_MUL:  return 1 + LAT_MUL;
      OP_DIV:  return 1 + LAT_DIV;
      OP_SQRT: return 1 + LAT_SQRT;
      default: return 0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op and returns #1 after its accept edge (ok=0 if never accepted).
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output bit ok);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_tests++; if (bus.unit_a !== 32'h0 || bus.unit_b !== 32'h0) begin n_fail++; $display("FAIL reset_unit_ab: got %h/%h want 0/0", bus.unit_a, bus.unit_b); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_mul();
    bit ok;
    int n;
    send(OP_MUL, 32'h40000000, 32'h40400000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mul_accept: got 0 want 1"); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b want 1", busy); end
    wait_valid(n);
    n_tests++; if (n != 1) begin n_fail++; $display("FAIL mul_latency: got %0d want 1", n); end
    n_tests++; if (bus.out_data !== 32'h40C00000) begin n_fail++; $display("FAIL mul_data: got %h want 40c00000", bus.out_data); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_retire: got valid=%b busy=%b want 0/0", bus.out_valid, busy); end
  endtask

  task automatic test_div();
    bit ok;
    bit stable;
    int n;
    send(OP_DIV, 32'h41200000, 32'h40000000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL div_accept: got 0 want 1"); end
    stable = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      if (bus.unit_a !== 32'h41200000 || bus.unit_b !== 32'h40000000) stable = 1'b0;
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      tick();
      n++;
    end
    n_tests++; if (!stable) begin n_fail++; $display("FAIL div_unit_stable: got 0 want 1"); end
    n_tests++; if (n != 4) begin n_fail++; $display("FAIL div_latency: got %0d want 4", n); end
    n_tests++; if (bus.out_data !== 32'h40A00000) begin n_fail++; $display("FAIL div_data: got %h want 40a00000", bus.out_data); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL div_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    send(OP_NEG, 32'h0, 32'h3F800000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_accept: got 0 want 1"); end
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MOV;
    bus.in_a     = 32'h0;
    bus.in_b     = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hBF800000 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h r=%b want 1/bf800000/0", i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_follow: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL bp_second: got v=%b d=%h want 1/0badf00d", bus.out_valid, bus.out_data); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit drop;
    logic [31:0] got[$];
    int cyc[$];
    bus.out_ready = 1'b1;
    send(OP_ADD, 32'h3F800000, 32'h3F800000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_accept: got 0 want 1"); end
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ABS;
    bus.in_b     = 32'hC0490FDB;
    for (int c = 0; c < 20 && got.size() < 2; c++) begin
      if (bus.out_valid) begin
        got.push_back(bus.out_data);
        cyc.push_back(c);
      end
      drop = bus.in_valid && bus.in_ready;
      tick();
      if (drop) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 2", got.size());
    end else begin
      n_tests += 2;
      if (got[0] !== 32'h40000000) begin n_fail++; $display("FAIL b2b_first: got %h want 40000000", got[0]); end
      if (got[1] !== 32'h40490FDB) begin n_fail++; $display("FAIL b2b_second: got %h want 40490fdb", got[1]); end
      n_tests++;
      if (cyc[1] != cyc[0] + 1) begin n_fail++; $display("FAIL b2b_gap: got cycles %0d,%0d want consecutive", cyc[0], cyc[1]); end
    end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_retire: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    int n;
    send(OP_SQRT, rand_f(), 32'h40800000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL flush_accept: got 0 want 1"); end
    tick();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MOV;
    bus.in_b     = 32'h12345678;
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got state=%0d busy=%b want %0d/0", dbg_state, busy, ST_IDLE); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL flush_no_result: got out_valid=1 want 0"); end
    send(OP_MOV, 32'h0, 32'h12345678, ok);
    wait_valid(n);
    n_tests++; if (n != 0 || bus.out_data !== 32'h12345678) begin n_fail++; $display("FAIL flush_next_mov: got n=%0d d=%h want 0/12345678", n, bus.out_data); end
    tick();
    // flush while idle leaves the sequencer idle
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++; if (dbg_state !== ST_IDLE || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_in_idle: got state=%0d v=%b want %0d/0", dbg_state, bus.out_valid, ST_IDLE); end
    // flush while holding a result drops it
    bus.out_ready = 1'b0;
    send(OP_MOV, 32'h0, 32'h0000BEEF, ok);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_pre: got %b want 1", bus.out_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++; if (bus.out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL flush_done: got v=%b state=%0d want 0/%0d", bus.out_valid, dbg_state, ST_IDLE); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    logic [31:0] a, b;
    send(OP_DIV, rand_f(), rand_f(), ok);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.unit_a !== 32'h0 || bus.unit_b !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b busy=%b d=%h ua=%h ub=%h want all 0", bus.out_valid, busy, bus.out_data, bus.unit_a, bus.unit_b);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++; if (bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL async_release: got r=%b state=%0d want 1/%0d", bus.in_ready, dbg_state, ST_IDLE); end
    a = rand_f();
    b = rand_f();
    send(OP_ADD, a, b, ok);
    wait_valid(n);
    n_tests++; if (n != 2 || bus.out_data !== exp_res(OP_ADD, a, b)) begin n_fail++; $display("FAIL async_add: got n=%0d d=%h want 2/%h", n, bus.out_data, exp_res(OP_ADD, a, b)); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [2:0]   op;
    logic [31:0]  a, b, e;
    bit           ok;
    int           n, stall;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_f();
      b  = rand_f();
      repeat ($urandom_range(0, 2)) tick();
      bus.out_ready = 1'b1;
      send(op, a, b, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_accept: got 0 want 1", i); end
      exp_q.push_back(exp_res(op, a, b));
      wait_valid(n);
      n_tests++; if (n != exp_lat(op)) begin n_fail++; $display("FAIL rnd%0d_latency: op=%0d got %0d want %0d", i, op, n, exp_lat(op)); end
      e = exp_q.pop_front();
      n_tests++; if (bus.out_data !== e) begin n_fail++; $display("FAIL rnd%0d_data: op=%0d got %h want %h", i, op, bus.out_data, e); end
      stall = $urandom_range(0, 2);
      bus.out_ready = (stall == 0);
      for (int k = 0; k < stall; k++) begin
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin n_fail++; $display("FAIL rnd%0d_stall: got v=%b d=%h want 1/%h", i, bus.out_valid, bus.out_data, e); end
      end
      bus.out_ready = 1'b1;
      tick();
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_retire: got %b want 0", i, bus.out_valid); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
